// File: rtl/gb_io_pkg.sv
// gb_io_pkg: shared GB I/O register offsets and timer tick-select table
package gb_io_pkg;
    typedef enum logic [1:0] {
        REG_DIV  = 2'd0,
        REG_TIMA = 2'd1,
        REG_TMA  = 2'd2,
        REG_TAC  = 2'd3
    } timer_reg_e;

    localparam logic [2:0] PEND_CLKS = 3'd4;

    function automatic logic [3:0] tac_bit(input logic [1:0] sel);
        return sel == 2'd0 ? 4'd9 : sel == 2'd1 ? 4'd3 : sel == 2'd2 ? 4'd5 : 4'd7;
    endfunction
endpackage

// File: rtl/gb_timer_div.sv
// gb_timer_div: free-running 16-bit divider with TAC tick select and falling-edge detect
module gb_timer_div
    import gb_io_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic [2:0] tac,
    output logic [7:0] div_hi,
    output logic       fall
);
    logic [15:0] div_q, div_d;
    logic        tick_q, tick_d;

    // DIV/TAC writes reach the tick through div_q/tac, so their falling edges are caught here too
    always_comb begin
        div_d  = clr ? 16'h0000 : div_q + 16'd1;
        tick_d = tac[2] & div_q[tac_bit(tac[1:0])];
        fall   = tick_q & ~tick_d;
        div_hi = div_q[15:8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= 16'h0000;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end
endmodule

// File: rtl/gb_timer.sv
// gb_timer: GB DIV/TIMA/TMA/TAC timer with overflow reload window, irq and bus readback
module gb_timer
    import gb_io_pkg::*;
#(
    parameter logic [15:0] BASE = 16'hff04
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] adr,
    input  logic [7:0]  din,
    input  logic        read,
    input  logic        write,
    output logic [7:0]  dout,
    output logic        ddrv,
    output logic        irq
);
    logic [7:0]  tima_q, tima_d, tma_q, tma_d, dout_q, dout_d, div_hi, rd_val;
    logic [2:0]  tac_q, tac_d, pend_q, pend_d;
    logic        ddrv_q, ddrv_d, irq_q, irq_d, hit, wr, div_clr, fall;
    logic [15:0] off;
    timer_reg_e  sel;

    gb_timer_div u_div (
        .clk    (clk),
        .reset  (reset),
        .clr    (div_clr),
        .tac    (tac_q),
        .div_hi (div_hi),
        .fall   (fall)
    );

    always_comb begin
        off     = adr - BASE;
        hit     = off[15:2] == 14'd0;
        sel     = timer_reg_e'(off[1:0]);
        wr      = write & hit;
        div_clr = wr && sel == REG_DIV;
        tma_d   = wr && sel == REG_TMA ? din : tma_q;
        tac_d   = wr && sel == REG_TAC ? din[2:0] : tac_q;
        pend_d  = pend_q != 3'd0 ? pend_q - 3'd1 : 3'd0;
        tima_d  = tima_q;
        irq_d   = 1'b0;
        // TIMA stays at 00 through the pending window; a CPU write cancels the reload
        if (wr && sel == REG_TIMA) begin
            tima_d = din;
            pend_d = 3'd0;
        end else if (pend_q == 3'd1) begin
            tima_d = tma_d;
            irq_d  = 1'b1;
        end else if (fall && pend_q == 3'd0) begin
            tima_d = tima_q + 8'd1;
            pend_d = tima_q == 8'hff ? PEND_CLKS : 3'd0;
        end
        rd_val = sel == REG_DIV  ? div_hi :
                 sel == REG_TIMA ? tima_q :
                 sel == REG_TMA  ? tma_q  : {5'b11111, tac_q};
        ddrv_d = read & hit;
        dout_d = ddrv_d ? rd_val : 8'h00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tima_q <= 8'h00;
            tma_q  <= 8'h00;
            tac_q  <= 3'd0;
            pend_q <= 3'd0;
            dout_q <= 8'h00;
            ddrv_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            tima_q <= tima_d;
            tma_q  <= tma_d;
            tac_q  <= tac_d;
            pend_q <= pend_d;
            dout_q <= dout_d;
            ddrv_q <= ddrv_d;
            irq_q  <= irq_d;
        end
    end

    assign dout = dout_q;
    assign ddrv = ddrv_q;
    assign irq  = irq_q;
endmodule

// File: tb/tb_gb_timer.sv
// tb_gb_timer: directed table-driven and sequence checks for gb_timer
module tb_gb_timer;
    logic        clk, reset, read, write, ddrv, irq;
    logic [15:0] adr;
    logic [7:0]  din, dout;
    int          total, bad, irq_seen;

    typedef struct {
        logic [15:0] adr;
        logic [7:0]  din;
        logic        rd;
        logic        wr;
        logic [7:0]  exp;
        logic        drv;
    } vec_t;
    vec_t tv[14];

    gb_timer #(.BASE(16'hff04)) dut (
        .clk   (clk),
        .reset (reset),
        .adr   (adr),
        .din   (din),
        .read  (read),
        .write (write),
        .dout  (dout),
        .ddrv  (ddrv),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (irq) irq_seen++;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [7:0] v, output logic d);
        adr  = a;
        read = 1'b1;
        cyc();
        v    = dout;
        d    = ddrv;
        read = 1'b0;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        adr   = a;
        din   = d;
        write = 1'b1;
        cyc();
        write = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        read  = 1'b0;
        write = 1'b0;
        adr   = 16'h0000;
        din   = 8'h00;
        repeat (2) cyc();
        reset = 1'b0;
    endtask

    // after this, TMA=f0, TIMA=fe, divider=1, TAC=05; edge n afterwards samples divider=n
    task automatic prep();
        do_reset();
        bus_wr(16'hff06, 8'hf0);
        bus_wr(16'hff05, 8'hfe);
        bus_wr(16'hff04, 8'h00);
        bus_wr(16'hff07, 8'h05);
    endtask

    logic [7:0] v, et;
    logic       d;

    initial begin
        total = 0;
        bad   = 0;
        irq_seen = 0;
        reset = 1'b1;
        read  = 1'b0;
        write = 1'b0;
        adr   = 16'h0000;
        din   = 8'h00;
        #1;
        chk("rst_dout", dout, 8'h00);
        chk("rst_ddrv", 8'(ddrv), 8'h00);
        chk("rst_irq", 8'(irq), 8'h00);

        // reset release, TAC=0, 1024 clocks
        do_reset();
        irq_seen = 0;
        repeat (1024) cyc();
        bus_rd(16'hff04, v, d);
        chk("s1_div", v, 8'h04);
        chk("s1_div_ddrv", 8'(d), 8'h01);
        bus_rd(16'hff05, v, d);
        chk("s1_tima", v, 8'h00);
        chk("s1_irq_none", 8'(irq_seen), 8'h00);

        // register access table; timer disabled so TIMA is static
        tv[0]  = '{16'hff06, 8'ha5, 1'b0, 1'b1, 8'h00, 1'b0};
        tv[1]  = '{16'hff06, 8'h00, 1'b1, 1'b0, 8'ha5, 1'b1};
        tv[2]  = '{16'hff05, 8'h3c, 1'b0, 1'b1, 8'h00, 1'b0};
        tv[3]  = '{16'hff05, 8'h00, 1'b1, 1'b0, 8'h3c, 1'b1};
        tv[4]  = '{16'hff07, 8'hfa, 1'b0, 1'b1, 8'h00, 1'b0};
        tv[5]  = '{16'hff07, 8'h00, 1'b1, 1'b0, 8'hfa, 1'b1};
        tv[6]  = '{16'hff08, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        tv[7]  = '{16'hff03, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        tv[8]  = '{16'hff06, 8'h77, 1'b1, 1'b1, 8'ha5, 1'b1};
        tv[9]  = '{16'hff06, 8'h00, 1'b1, 1'b0, 8'h77, 1'b1};
        tv[10] = '{16'hff04, 8'hff, 1'b0, 1'b1, 8'h00, 1'b0};
        tv[11] = '{16'hff04, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
        tv[12] = '{16'hff08, 8'h11, 1'b0, 1'b1, 8'h00, 1'b0};
        tv[13] = '{16'hff05, 8'h00, 1'b1, 1'b0, 8'h3c, 1'b1};
        for (int i = 0; i < 14; i++) begin
            adr   = tv[i].adr;
            din   = tv[i].din;
            read  = tv[i].rd;
            write = tv[i].wr;
            cyc();
            read  = 1'b0;
            write = 1'b0;
            chk($sformatf("tv%0d_ddrv", i), 8'(ddrv), 8'(tv[i].drv));
            if (tv[i].drv) chk($sformatf("tv%0d_dout", i), dout, tv[i].exp);
        end

        // TAC=05 count-up through overflow, pending window and reload
        prep();
        for (int n = 1; n <= 40; n++) begin
            bus_rd(16'hff05, v, d);
            chk($sformatf("s2_irq_e%0d", n), 8'(irq), 8'(n == 36));
            if (n == 16 || n == 17 || n == 32 || n == 33 || n == 35 || n == 37) begin
                et = n == 16 ? 8'hfe : n == 17 ? 8'hff : n == 32 ? 8'hff :
                     n == 37 ? 8'hf0 : 8'h00;
                chk($sformatf("s2_tima_e%0d", n), v, et);
            end
        end

        // TIMA write inside the pending window cancels reload and irq
        prep();
        irq_seen = 0;
        repeat (33) cyc();
        bus_wr(16'hff05, 8'h55);
        bus_rd(16'hff05, v, d);
        chk("s3_tima_now", v, 8'h55);
        repeat (5) cyc();
        bus_rd(16'hff05, v, d);
        chk("s3_tima_later", v, 8'h55);
        chk("s3_irq_none", 8'(irq_seen), 8'h00);

        // DIV write while selected bit is high produces an extra tick
        prep();
        repeat (8) cyc();
        bus_wr(16'hff04, 8'hab);
        bus_rd(16'hff04, v, d);
        chk("s4_div", v, 8'h00);
        bus_rd(16'hff05, v, d);
        chk("s4_tima", v, 8'hff);

        // TAC readback and unmapped address
        bus_wr(16'hff07, 8'h06);
        bus_rd(16'hff07, v, d);
        chk("s5_tac", v, 8'hfe);
        chk("s5_tac_ddrv", 8'(d), 8'h01);
        bus_rd(16'hff08, v, d);
        chk("s5_unmapped_ddrv", 8'(d), 8'h00);

        // reset for one clock in the middle of the pending window
        prep();
        repeat (32) cyc();
        bus_rd(16'hff06, v, d);
        chk("s6_tma_pre", v, 8'hf0);
        irq_seen = 0;
        reset = 1'b1;
        #1;
        chk("s6_async_dout", dout, 8'h00);
        chk("s6_async_ddrv", 8'(ddrv), 8'h00);
        cyc();
        reset = 1'b0;
        bus_rd(16'hff04, v, d);
        chk("s6_div", v, 8'h00);
        bus_rd(16'hff05, v, d);
        chk("s6_tima", v, 8'h00);
        bus_rd(16'hff06, v, d);
        chk("s6_tma", v, 8'h00);
        bus_rd(16'hff07, v, d);
        chk("s6_tac", v, 8'hf8);
        repeat (8) cyc();
        chk("s6_irq_none", 8'(irq_seen), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
